// File: rtl/turn_sequencer.sv
// turn_sequencer: game-flow controller for the tile-matching race.
// Accepts a pick from the player whose turn it is, shows the tile for a fixed
// reveal window, then steps that player's chicken forward (strobe B) on a match
// or hands the turn to the next player on a miss. After every step it samples
// the win checker's W flag and freezes the game when it is set.
//
// Optional feature, enabled by defining the macro PICK_TIMEOUT_EN:
//   adds parameter TIMEOUT_CYCLES. A player who makes no pick within that many
//   cycles loses the turn as if the pick had been a miss. Without the macro,
//   PICK waits indefinitely and no timeout counter exists.
//
// Handshake: a pick is accepted on any rising clock edge where pick_ready and
// pick_valid are both high. pick_tile and next_tile are sampled on that same
// edge. pick_ready is registered and is high only while the FSM waits in PICK.
module turn_sequencer #(
    parameter int TILE_W        = 4,
    parameter int NUM_PLAYERS   = 3,
    parameter int REVEAL_CYCLES = 50000000
`ifdef PICK_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 250000000
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              pick_valid,
    input  logic [TILE_W-1:0] pick_tile,
    input  logic [TILE_W-1:0] next_tile,
    input  logic              W,
    output logic [1:0]        T,
    output logic              B,
    output logic              reveal,
    output logic              pick_ready,
    output logic              game_over,
    output logic [1:0]        winner
);

    // The reveal counter only has to hold REVEAL_CYCLES-1.
    localparam int               CNT_W    = (REVEAL_CYCLES > 1) ? $clog2(REVEAL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(REVEAL_CYCLES - 1);
    localparam logic [1:0]       LAST_T   = 2'(NUM_PLAYERS - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PICK      = 3'd1,
        S_REVEAL    = 3'd2,
        S_RESOLVE   = 3'd3,
        S_WIN_CHECK = 3'd4,
        S_OVER      = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        t_q, t_d;
    logic              b_q, b_d;
    logic              reveal_q, reveal_d;
    logic              pick_ready_q, pick_ready_d;
    logic              game_over_q, game_over_d;
    logic [1:0]        winner_q, winner_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TILE_W-1:0] pick_q, pick_d;
    logic              match_q, match_d;
    logic [1:0]        next_t;

`ifdef PICK_TIMEOUT_EN
    localparam int               TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

    // Turn rotation wraps after the last active player so T stays in range.
    assign next_t = (t_q == LAST_T) ? 2'd0 : t_q + 2'd1;

    // Next-state and next-output logic; every output is computed one cycle
    // ahead so that it leaves the block straight from a flop.
    always_comb begin
        state_d      = state_q;
        t_d          = t_q;
        b_d          = 1'b0;
        reveal_d     = reveal_q;
        pick_ready_d = pick_ready_q;
        game_over_d  = game_over_q;
        winner_d     = winner_q;
        cnt_d        = cnt_q;
        pick_d       = pick_q;
        match_d      = match_q;
`ifdef PICK_TIMEOUT_EN
        tmo_d        = tmo_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_PICK;
                    t_d          = 2'd0;
                    pick_ready_d = 1'b1;
`ifdef PICK_TIMEOUT_EN
                    tmo_d        = '0;
`endif
                end
            end
            S_PICK: begin
                // A real pick always beats a timeout expiring in the same cycle.
                if (pick_valid) begin
                    pick_d       = pick_tile;
                    match_d      = (pick_tile == next_tile);
                    cnt_d        = CNT_LOAD;
                    state_d      = S_REVEAL;
                    pick_ready_d = 1'b0;
                    reveal_d     = 1'b1;
                end
`ifdef PICK_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    t_d   = next_t;
                    tmo_d = '0;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
`endif
            end
            S_REVEAL: begin
                if (cnt_q == '0) begin
                    state_d  = S_RESOLVE;
                    reveal_d = 1'b0;
                    b_d      = match_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESOLVE: begin
                if (match_q) begin
                    state_d = S_WIN_CHECK;
                end else begin
                    t_d          = next_t;
                    state_d      = S_PICK;
                    pick_ready_d = 1'b1;
`ifdef PICK_TIMEOUT_EN
                    tmo_d        = '0;
`endif
                end
            end
            S_WIN_CHECK: begin
                // The checker has had one cycle to absorb B; W is trusted only here.
                if (W) begin
                    winner_d    = t_q;
                    game_over_d = 1'b1;
                    state_d     = S_OVER;
                end else begin
                    state_d      = S_PICK;
                    pick_ready_d = 1'b1;
`ifdef PICK_TIMEOUT_EN
                    tmo_d        = '0;
`endif
                end
            end
            S_OVER: begin
                if (start) begin
                    state_d      = S_PICK;
                    t_d          = 2'd0;
                    game_over_d  = 1'b0;
                    winner_d     = 2'd0;
                    pick_ready_d = 1'b1;
`ifdef PICK_TIMEOUT_EN
                    tmo_d        = '0;
`endif
                end
            end
            default: begin
                state_d      = S_IDLE;
                t_d          = 2'd0;
                reveal_d     = 1'b0;
                pick_ready_d = 1'b0;
                game_over_d  = 1'b0;
                winner_d     = 2'd0;
            end
        endcase
    end

    // State and output registers; reset drops any pending step strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            t_q          <= 2'd0;
            b_q          <= 1'b0;
            reveal_q     <= 1'b0;
            pick_ready_q <= 1'b0;
            game_over_q  <= 1'b0;
            winner_q     <= 2'd0;
            cnt_q        <= '0;
            pick_q       <= '0;
            match_q      <= 1'b0;
`ifdef PICK_TIMEOUT_EN
            tmo_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            t_q          <= t_d;
            b_q          <= b_d;
            reveal_q     <= reveal_d;
            pick_ready_q <= pick_ready_d;
            game_over_q  <= game_over_d;
            winner_q     <= winner_d;
            cnt_q        <= cnt_d;
            pick_q       <= pick_d;
            match_q      <= match_d;
`ifdef PICK_TIMEOUT_EN
            tmo_q        <= tmo_d;
`endif
        end
    end

    assign T          = t_q;
    assign B          = b_q;
    assign reveal     = reveal_q;
    assign pick_ready = pick_ready_q;
    assign game_over  = game_over_q;
    assign winner     = winner_q;

endmodule

// File: tb/tb_turn_sequencer.sv
// tb_turn_sequencer: self-checking bench for turn_sequencer with
// REVEAL_CYCLES=4, NUM_PLAYERS=3. Expected values come from a turn-level
// game model (whose turn it is, who won) kept in this file.
`timescale 1ns/1ps
module tb_turn_sequencer;

    localparam int TILE_W        = 4;
    localparam int NUM_PLAYERS   = 3;
    localparam int REVEAL_CYCLES = 4;
`ifdef PICK_TIMEOUT_EN
    localparam int TIMEOUT_CYCLES = 10;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic              clk        = 1'b0;
    logic              rst_n      = 1'b0;
    logic              start      = 1'b0;
    logic              pick_valid = 1'b0;
    logic [TILE_W-1:0] pick_tile  = '0;
    logic [TILE_W-1:0] next_tile  = '0;
    logic              W          = 1'b0;
    logic [1:0]        T;
    logic              B;
    logic              reveal;
    logic              pick_ready;
    logic              game_over;
    logic [1:0]        winner;
    logic [7:0]        outs;

    always #5 clk = ~clk;

    turn_sequencer #(
        .TILE_W        (TILE_W),
        .NUM_PLAYERS   (NUM_PLAYERS),
        .REVEAL_CYCLES (REVEAL_CYCLES)
`ifdef PICK_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
`endif
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .pick_valid(pick_valid),
        .pick_tile (pick_tile),
        .next_tile (next_tile),
        .W         (W),
        .T         (T),
        .B         (B),
        .reveal    (reveal),
        .pick_ready(pick_ready),
        .game_over (game_over),
        .winner    (winner)
    );

    // Packed view of all outputs: {T, winner, B, reveal, pick_ready, game_over}
    assign outs = {T, winner, B, reveal, pick_ready, game_over};

    int errors = 0;
    int checks = 0;

    // ---------------- game model ----------------
    int         exp_t    = 0;
    logic [1:0] exp_win  = 2'd0;
    bit         exp_over = 1'b0;
    logic [1:0] exp_q[$];
    bit         w_noise_en = 1'b1;
    logic       w_idle     = 1'b0;

    function automatic logic [7:0] exp_outs();
        return {2'(exp_t), exp_win, 1'b0, 1'b0, ~exp_over, exp_over};
    endfunction

    task automatic model_new_game();
        exp_t    = 0;
        exp_win  = 2'd0;
        exp_over = 1'b0;
    endtask

    task automatic model_turn(input bit match, input bit w);
        if (match && w) begin
            exp_over = 1'b1;
            exp_win  = 2'(exp_t);
        end else if (!match) begin
            exp_t = (exp_t + 1) % NUM_PLAYERS;
        end
    endtask

    // ---------------- monitor: T range and B spacing ----------------
    int cyc        = 0;
    int last_b_cyc = -1;
    int last_gap   = 0;
    bit mon_en     = 1'b0;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            checks++;
            if (int'(T) >= NUM_PLAYERS) begin
                errors++;
                $display("FAIL t_range: T=%0d, required < %0d", T, NUM_PLAYERS);
            end
            if (B === 1'b1) begin
                if (last_b_cyc >= 0) begin
                    last_gap = cyc - last_b_cyc;
                    checks++;
                    if (last_gap < REVEAL_CYCLES + 3) begin
                        errors++;
                        $display("FAIL b_spacing: gap=%0d, required >= %0d", last_gap, REVEAL_CYCLES + 3);
                    end
                end
                last_b_cyc = cyc;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one pick from PICK and walks the DUT through reveal and resolution,
    // returning in PICK (or OVER) just after the state change.
    task automatic drive_pick(input logic [TILE_W-1:0] p, input logic [TILE_W-1:0] n,
                              input logic w, output int rlen, output int bres,
                              output int bext, output int rdy_hi);
        rlen   = 0;
        bres   = 0;
        bext   = 0;
        rdy_hi = 0;
        pick_tile  = p;
        next_tile  = n;
        pick_valid = 1'b1;
        tick();
        pick_valid = 1'b0;
        pick_tile  = TILE_W'($urandom);
        next_tile  = TILE_W'($urandom);
        while (reveal === 1'b1 && rlen < 4 * REVEAL_CYCLES + 8) begin
            rlen++;
            if (B === 1'b1) bext++;
            if (pick_ready === 1'b1) rdy_hi++;
            W = w_noise_en ? 1'($urandom_range(0, 1)) : w_idle;
            tick();
        end
        if (B === 1'b1) bres = 1;
        if (pick_ready === 1'b1) rdy_hi++;
        if (p == n) begin
            tick();
            if (B === 1'b1) bext++;
            if (pick_ready === 1'b1) rdy_hi++;
            W = w;
            tick();
        end else begin
            tick();
        end
        W = w_idle;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if (outs !== 8'h00) begin
            errors++;
            $display("FAIL reset_values: outs=0x%0h, required 0x00", outs);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        pick_valid = 1'b1;
        pick_tile  = 4'd3;
        next_tile  = 4'd3;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (outs !== 8'h00) begin
                errors++;
                $display("FAIL idle_ignores_pick: outs=0x%0h, required 0x00", outs);
            end
        end
        pick_valid = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_match();
        int rlen, bres, bext, rdy;
        start = 1'b1;
        tick();
        start = 1'b0;
        model_new_game();
        checks++;
        if (outs !== exp_outs()) begin
            errors++;
            $display("FAIL start_state: outs=0x%0h, required 0x%0h", outs, exp_outs());
        end
        drive_pick(4'd5, 4'd5, 1'b0, rlen, bres, bext, rdy);
        model_turn(1'b1, 1'b0);
        checks++;
        if (rlen !== REVEAL_CYCLES) begin
            errors++;
            $display("FAIL match_reveal_len: got %0d, required %0d", rlen, REVEAL_CYCLES);
        end
        checks++;
        if (bres !== 1 || bext !== 0) begin
            errors++;
            $display("FAIL match_b_pulse: resolve=%0d other=%0d, required 1 and 0", bres, bext);
        end
        checks++;
        if (rdy !== 0) begin
            errors++;
            $display("FAIL match_ready_low: high %0d cycles, required 0", rdy);
        end
        checks++;
        if (outs !== exp_outs()) begin
            errors++;
            $display("FAIL match_after: outs=0x%0h, required 0x%0h", outs, exp_outs());
        end
    endtask

    task automatic test_miss_rotation();
        int rlen, bres, bext, rdy;
        logic [1:0] want;
        for (int i = 0; i < 3; i++) begin
            model_turn(1'b0, 1'b0);
            exp_q.push_back(2'(exp_t));
        end
        for (int i = 0; i < 3; i++) begin
            drive_pick(4'd2, 4'd7, 1'b0, rlen, bres, bext, rdy);
            want = exp_q.pop_front();
            checks++;
            if (T !== want) begin
                errors++;
                $display("FAIL miss_rotation[%0d]: T=%0d, required %0d", i, T, want);
            end
            checks++;
            if (bres !== 0 || bext !== 0 || rlen !== REVEAL_CYCLES) begin
                errors++;
                $display("FAIL miss_no_b[%0d]: b=%0d/%0d rlen=%0d, required 0/0 rlen %0d",
                         i, bres, bext, rlen, REVEAL_CYCLES);
            end
        end
    endtask

    task automatic test_win();
        int rlen, bres, bext, rdy;
        drive_pick(4'd1, 4'd8, 1'b0, rlen, bres, bext, rdy);
        model_turn(1'b0, 1'b0);
        drive_pick(4'd6, 4'd6, 1'b1, rlen, bres, bext, rdy);
        model_turn(1'b1, 1'b1);
        checks++;
        if (outs !== exp_outs()) begin
            errors++;
            $display("FAIL win_state: outs=0x%0h, required 0x%0h", outs, exp_outs());
        end
        pick_valid = 1'b1;
        pick_tile  = 4'd4;
        next_tile  = 4'd4;
        W = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (outs !== exp_outs()) begin
                errors++;
                $display("FAIL over_frozen[%0d]: outs=0x%0h, required 0x%0h", i, outs, exp_outs());
            end
        end
        pick_valid = 1'b0;
        W = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        model_new_game();
        checks++;
        if (outs !== exp_outs()) begin
            errors++;
            $display("FAIL restart_from_over: outs=0x%0h, required 0x%0h", outs, exp_outs());
        end
    endtask

    task automatic test_reset_mid_reveal();
        pick_valid = 1'b1;
        pick_tile  = 4'd9;
        next_tile  = 4'd9;
        tick();
        pick_valid = 1'b0;
        tick();
        checks++;
        if (reveal !== 1'b1) begin
            errors++;
            $display("FAIL second_reveal_cycle: reveal=%0b, required 1", reveal);
        end
        rst_n = 1'b0;
        #1;
        model_new_game();
        checks++;
        if (outs !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: outs=0x%0h, required 0x00", outs);
        end
        for (int i = 0; i < REVEAL_CYCLES + 2; i++) begin
            tick();
            checks++;
            if (outs !== 8'h00) begin
                errors++;
                $display("FAIL reset_hold[%0d]: outs=0x%0h, required 0x00", i, outs);
            end
        end
        rst_n = 1'b1;
        last_b_cyc = -1;
        pick_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (outs !== 8'h00) begin
                errors++;
                $display("FAIL post_reset_idle[%0d]: outs=0x%0h, required 0x00", i, outs);
            end
        end
        pick_valid = 1'b0;
    endtask

    task automatic test_w_ignored();
        int rlen, bres, bext, rdy;
        w_noise_en = 1'b0;
        w_idle     = 1'b1;
        W          = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        model_new_game();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (outs !== exp_outs()) begin
                errors++;
                $display("FAIL w_high_in_pick[%0d]: outs=0x%0h, required 0x%0h", i, outs, exp_outs());
            end
        end
        drive_pick(4'd2, 4'd7, 1'b1, rlen, bres, bext, rdy);
        model_turn(1'b0, 1'b1);
        checks++;
        if (outs !== exp_outs()) begin
            errors++;
            $display("FAIL w_high_miss: outs=0x%0h, required 0x%0h", outs, exp_outs());
        end
        w_noise_en = 1'b1;
        w_idle     = 1'b0;
        W          = 1'b0;
    endtask

    task automatic test_back_to_back();
        int rlen, bres, bext, rdy;
        drive_pick(4'd4, 4'd4, 1'b0, rlen, bres, bext, rdy);
        model_turn(1'b1, 1'b0);
        drive_pick(4'd11, 4'd11, 1'b0, rlen, bres, bext, rdy);
        model_turn(1'b1, 1'b0);
        checks++;
        if (last_gap !== REVEAL_CYCLES + 3) begin
            errors++;
            $display("FAIL b_min_gap: gap=%0d, required %0d", last_gap, REVEAL_CYCLES + 3);
        end
        checks++;
        if (outs !== exp_outs()) begin
            errors++;
            $display("FAIL back_to_back_state: outs=0x%0h, required 0x%0h", outs, exp_outs());
        end
    endtask

`ifdef PICK_TIMEOUT_EN
    task automatic test_pick_timeout();
        int rlen, bres, bext, rdy;
        start = 1'b1;
        tick();
        start = 1'b0;
        model_new_game();
        for (int i = 1; i <= TIMEOUT_CYCLES; i++) begin
            tick();
            if (i == TIMEOUT_CYCLES) exp_t = (exp_t + 1) % NUM_PLAYERS;
            checks++;
            if (outs !== exp_outs()) begin
                errors++;
                $display("FAIL timeout_wait[%0d]: outs=0x%0h, required 0x%0h", i, outs, exp_outs());
            end
        end
        repeat (TIMEOUT_CYCLES - 1) tick();
        drive_pick(4'd2, 4'd7, 1'b0, rlen, bres, bext, rdy);
        model_turn(1'b0, 1'b0);
        checks++;
        if (rlen !== REVEAL_CYCLES || outs !== exp_outs()) begin
            errors++;
            $display("FAIL pick_beats_timeout: rlen=%0d outs=0x%0h, required %0d 0x%0h",
                     rlen, outs, REVEAL_CYCLES, exp_outs());
        end
    endtask
`else
    task automatic test_no_timeout();
        for (int i = 0; i < 40; i++) begin
            tick();
            checks++;
            if (outs !== exp_outs()) begin
                errors++;
                $display("FAIL pick_waits[%0d]: outs=0x%0h, required 0x%0h", i, outs, exp_outs());
            end
        end
    endtask
`endif

    task automatic test_random_game();
        int rlen, bres, bext, rdy;
        bit match, w;
        logic [TILE_W-1:0] p, n;
        for (int i = 0; i < 30; i++) begin
            match = 1'($urandom_range(0, 1));
            w     = ($urandom_range(0, 3) == 0);
            p     = TILE_W'($urandom);
            n     = match ? p : (p ^ TILE_W'($urandom_range(1, 15)));
            drive_pick(p, n, w, rlen, bres, bext, rdy);
            model_turn(match, w);
            checks++;
            if (rlen !== REVEAL_CYCLES || bres !== int'(match) || bext !== 0 || rdy !== 0) begin
                errors++;
                $display("FAIL rand_turn[%0d]: rlen=%0d b=%0d/%0d rdy=%0d, required %0d %0d/0 0",
                         i, rlen, bres, bext, rdy, REVEAL_CYCLES, match);
            end
            checks++;
            if (outs !== exp_outs()) begin
                errors++;
                $display("FAIL rand_state[%0d]: outs=0x%0h, required 0x%0h", i, outs, exp_outs());
            end
            if (exp_over) begin
                start = 1'b1;
                tick();
                start = 1'b0;
                model_new_game();
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_match();
        test_miss_rotation();
        test_win();
        test_reset_mid_reveal();
        test_w_ignored();
        test_back_to_back();
`ifdef PICK_TIMEOUT_EN
        test_pick_timeout();
`else
        test_no_timeout();
`endif
        test_random_game();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
